// File: rtl/param_stack_if.sv
// Push/pop request and status bundle for param_stack.
// The stack is the slave. The driving side uses the master modport.
interface param_stack_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] Data_In;
  logic [WIDTH-1:0] Data_Out;
  logic [CW-1:0]    Count;
  logic             Full;
  logic             Empty;
  logic             AlmostFull;
  logic             Error;

  modport master (
    output push, pop, Data_In,
    input  Data_Out, Count, Full, Empty, AlmostFull, Error
  );

  modport slave (
    input  push, pop, Data_In,
    output Data_Out, Count, Full, Empty, AlmostFull, Error
  );
endinterface

// File: rtl/param_stack.sv
// Parameterised LIFO stack with registered data, occupancy, flags and error.
// Define PARAM_STACK_STICKY_ERR_EN to hold Error until reset. Without it, Error is a one-cycle pulse.
module param_stack #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input logic         Clk,
  input logic         Rst,
  param_stack_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   AF_C    = (CW + 1)'(AF_LEVEL);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CW-1:0]    count_r, count_s;
  logic [WIDTH-1:0] dout_r, dout_s;
  logic             err_r, err_s, fault_s;
  logic             full_r, empty_r, af_r;
  logic             wr_en_s;
  logic [AW-1:0]    wr_addr_s, top_s;

  assign top_s = AW'(count_r - CW'(1));

  // Next-state decode for each push/pop combination
  always_comb begin
    count_s   = count_r;
    dout_s    = dout_r;
    fault_s   = 1'b0;
    wr_en_s   = 1'b0;
    wr_addr_s = top_s;
    case ({bus.push, bus.pop})
      2'b10: begin
        if (count_r != DEPTH_C) begin
          wr_en_s   = 1'b1;
          wr_addr_s = AW'(count_r);
          count_s   = count_r + CW'(1);
        end else begin
          fault_s = 1'b1;
        end
      end
      2'b01: begin
        if (count_r != CW'(0)) begin
          dout_s  = mem_r[top_s];
          count_s = count_r - CW'(1);
        end else begin
          fault_s = 1'b1;
        end
      end
      2'b11: begin
        // Replace the top entry, or pass the word straight through when empty
        if (count_r != CW'(0)) begin
          dout_s  = mem_r[top_s];
          wr_en_s = 1'b1;
        end else begin
          dout_s = bus.Data_In;
        end
      end
      default: begin
        count_s = count_r;
      end
    endcase
  end

  // Error policy: sticky or single-cycle pulse
  always_comb begin
`ifdef PARAM_STACK_STICKY_ERR_EN
    err_s = err_r | fault_s;
`else
    err_s = fault_s;
`endif
  end

  // Storage write. Memory is not reset, and writes are suppressed while in reset.
  always_ff @(posedge Clk) begin
    if (wr_en_s && !Rst) begin
      mem_r[wr_addr_s] <= bus.Data_In;
    end
  end

  // Pointer, output data, error and status flag registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_r <= CW'(0);
      dout_r  <= WIDTH'(0);
      err_r   <= 1'b0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= (AF_C == (CW + 1)'(0));
    end else begin
      count_r <= count_s;
      dout_r  <= dout_s;
      err_r   <= err_s;
      full_r  <= (count_s == DEPTH_C);
      empty_r <= (count_s == CW'(0));
      af_r    <= ({1'b0, count_s} >= AF_C);
    end
  end

  assign bus.Count      = count_r;
  assign bus.Data_Out   = dout_r;
  assign bus.Error      = err_r;
  assign bus.Full       = full_r;
  assign bus.Empty      = empty_r;
  assign bus.AlmostFull = af_r;
endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack (WIDTH=4, DEPTH=8, AF_LEVEL=7).
// The driver queues the hand-computed expectation for each edge. The monitor compares it on the next falling edge.
module tb_param_stack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_stack_if #(.WIDTH(4), .DEPTH(8)) bus ();
  param_stack #(.WIDTH(4), .DEPTH(8), .AF_LEVEL(7)) dut (.Clk(clk), .Rst(rst), .bus(bus));

  typedef struct {
    int         step;
    logic [3:0] cnt;
    logic [3:0] dout;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;
  logic err_seen = 1'b0;

  task automatic chk(input string name, input int step, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step=%0d actual=%0d required=%0d", name, step, act, req);
    end
  endtask

  // Monitor: outputs are stable on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count",      e.step, 4'(bus.Count),      e.cnt);
      chk("data_out",   e.step, bus.Data_Out,       e.dout);
      chk("error",      e.step, 4'(bus.Error),      4'(e.err));
      chk("full",       e.step, 4'(bus.Full),       4'(e.cnt == 4'd8));
      chk("empty",      e.step, 4'(bus.Empty),      4'(e.cnt == 4'd0));
      chk("almostfull", e.step, 4'(bus.AlmostFull), 4'(e.cnt >= 4'd7));
    end
  end

  // Drive one edge. ecnt/edout are hand-computed; efault marks an offending edge.
  task automatic step(input logic r, input logic pu, input logic po, input logic [3:0] din,
                      input logic [3:0] ecnt, input logic [3:0] edout, input logic efault);
    exp_t e;
    rst         = r;
    bus.push    = pu;
    bus.pop     = po;
    bus.Data_In = din;
    @(posedge clk);
    #1;
    step_no++;
`ifdef PARAM_STACK_STICKY_ERR_EN
    err_seen = r ? 1'b0 : (err_seen | efault);
`else
    err_seen = r ? 1'b0 : efault;
`endif
    e.step = step_no;
    e.cnt  = ecnt;
    e.dout = edout;
    e.err  = err_seen;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.Data_In = 4'd0;
    @(negedge clk);
    // Reset, then underflow.
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    // Fill with 1..8, then overflow with 9.
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 4'(i), 4'(i), 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd9, 4'd8, 4'd0, 1'b1);
    // Drain: 8..1, then underflow.
    for (int i = 8; i >= 1; i--) step(1'b0, 1'b0, 1'b1, 4'd0, 4'(i - 1), 4'(i), 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd1, 1'b1);
    // Replace-top with 11,12,13 on the stack.
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd11, 4'd1, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd12, 4'd2, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd13, 4'd3, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'd14, 4'd3, 4'd13, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 4'd14, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 4'd12, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd11, 1'b0);
    // Bypass when empty.
    step(1'b0, 1'b1, 1'b1, 4'd5, 4'd0, 4'd5, 1'b0);
    // Reset wins over push at Count=4.
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, 4'(i), 4'(i), 4'd5, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd3, 4'd1, 4'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd3, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0);
    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width in bits (1..32).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (2..256).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-1, occupancy at or above which AlmostFull asserts.
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port Rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port push  input  1  push request.
REQ-007 SHALL have port pop  input  1  pop request.
REQ-008 SHALL have port Data_In  input  WIDTH  word to push.
REQ-009 SHALL have port Data_Out  output  WIDTH  registered popped word.
REQ-010 SHALL have port Count  output  $clog2(DEPTH+1)  registered occupancy.
REQ-011 SHALL have ports Full, Empty, AlmostFull  output  1 each  status flags decoded from Count.
REQ-012 SHALL have port Error  output  1  registered overflow/underflow indication.

Function
REQ-013 SHALL be LIFO: storage is DEPTH x WIDTH array plus Count as stack pointer; top entry = mem[Count-1].
REQ-014 SHALL on push only, Count<DEPTH: mem[Count]<=Data_In, Count<=Count+1; Data_Out holds.
REQ-015 SHALL on pop only, Count>0: Data_Out<=mem[Count-1], Count<=Count-1; latency one edge (value visible after the edge that accepts the pop).
REQ-016 SHALL on push and pop, Count>0 (incl. full): Data_Out<=old top, mem[Count-1]<=Data_In, Count unchanged, no error (replace-top).
REQ-017 SHALL on push and pop, Count=0: Data_Out<=Data_In (bypass), Count stays 0, no error.
REQ-018 SHALL on push only with Count=DEPTH: drop the write, Count and memory unchanged, flag overflow.
REQ-019 SHALL on pop only with Count=0: Data_Out unchanged, Count unchanged, flag underflow.
REQ-020 SHALL drive Full=(Count==DEPTH), Empty=(Count==0), AlmostFull=(Count>=AF_LEVEL), all consistent with Count in the same cycle.
REQ-021 SHALL treat X-free idle (push=0, pop=0) as hold of all registers; Error deasserts per REQ-025/REQ-026.
REQ-022 SHALL never let Count exceed DEPTH or wrap below 0 under any input sequence.

Reset
REQ-023 SHALL, on an edge with Rst=1, set Count=0, Data_Out=0, Error=0; Empty=1, Full=0, AlmostFull=(AF_LEVEL==0); memory contents need not be cleared.
REQ-024 SHALL give Rst priority over push/pop in the same cycle; operations in progress are discarded, first accepted op is on the first edge with Rst=0.

Configuration
REQ-025 SHALL, with macro PARAM_STACK_STICKY_ERR_EN defined, hold Error=1 from the edge of the first overflow/underflow until the next reset edge.
REQ-026 SHALL, without PARAM_STACK_STICKY_ERR_EN, assert Error for exactly one cycle per offending edge (registered pulse), 0 otherwise.

Verification (WIDTH=4, DEPTH=8, AF_LEVEL=7)
REQ-027 SHALL cover: reset, then pop -> Error=1 (one cycle unless sticky), Count=0, Empty=1, Data_Out=0.
REQ-028 SHALL cover: push 1..8 on consecutive edges -> Count=8, Full=1, AlmostFull=1 from Count=7; ninth push of 9 -> Error=1, Count=8, later pops unaffected.
REQ-029 SHALL cover: from full, pop 8 times -> Data_Out sequence 8,7,6,5,4,3,2,1, Empty=1 after eighth; ninth pop -> Error=1.
REQ-030 SHALL cover: Count=3 holding 11,12,13, push 14 with pop -> Data_Out=13, Count=3, next pop -> Data_Out=14.
REQ-031 SHALL cover: empty, push 5 with pop -> Data_Out=5, Count=0, Error=0; Rst=1 with push=1 at Count=4 -> Count=0, Data_Out=0, no write.
REQ-032 SHALL run REQ-027..REQ-028 with and without PARAM_STACK_STICKY_ERR_EN: sticky Error stays 1 after good pops until Rst; pulse build returns Error to 0 next cycle.
